plab4_net_route_compute_unit: RTL and testbench

- Registered, flow-controlled route-compute stage for the ring router input path.
- Takes each message, computes its output direction from the destination field, and buffers message, route and domain in a 2-entry queue ahead of the switch.
- Generalises greedy routing in three ways:
  - any ring size, with correct modulo-N hop arithmetic;
  - selectable routing mode;
  - fair alternating tie-break for equidistant destinations.

---
 rtl/plab4_net_route_compute_unit.sv | 115 +++++++++++
 tb/tb_plab4_net_route_compute_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_route_compute_unit.sv
// plab4_net_route_compute_unit: registered ring route-compute stage with a 2-entry output queue
// Optional macro PLAB4_NET_ROUTE_STATS_EN adds saturating per-route dequeue counters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode_i            00 greedy, 01 oneway-next, 10 oneway-prev, 11 greedy
//   in_msg_i/in_domain_i/in_val_i/in_rdy_o      input message stream
//   out_msg_o/out_route_o/out_domain_o/out_val_o/out_rdy_i  head of queue
//   out_route_o       00 PREV, 01 NEXT, 10 TERM, 11 ERR
//   stat_prev_o/stat_next_o/stat_term_o  dequeue counters (macro only)
module plab4_net_route_compute_unit #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 32,
  parameter int p_dest_lsb    = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode_i,
  input  logic                   in_domain_i,
  input  logic [p_msg_nbits-1:0] in_msg_i,
  input  logic                   in_val_i,
  output logic                   in_rdy_o,
  output logic [p_msg_nbits-1:0] out_msg_o,
  output logic [1:0]             out_route_o,
  output logic                   out_domain_o,
  output logic                   out_val_o,
  input  logic                   out_rdy_i
`ifdef PLAB4_NET_ROUTE_STATS_EN
  ,
  output logic [15:0]            stat_prev_o,
  output logic [15:0]            stat_next_o,
  output logic [15:0]            stat_term_o
`endif
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  typedef logic [c_dest_nbits:0] hop_t;
  localparam hop_t c_id = hop_t'(p_router_id);
  localparam hop_t c_n  = hop_t'(p_num_routers);
  logic [p_msg_nbits-1:0] msg_q [2];
  logic [1:0]             route_q [2];
  logic                   dom_q [2];
  logic                   head_q, tail_q, tog_q, tog_d;
  logic [1:0]             count_q, count_d;
  logic [c_dest_nbits-1:0] dest;
  hop_t                   dest_x, forw, backw;
  logic [1:0]             route;
  logic                   tie, enq, deq;
  // Hop distances carry one extra bit so dest+N never wraps for non power-of-two N.
  always_comb begin
    dest   = in_msg_i[p_dest_lsb +: c_dest_nbits];
    dest_x = {1'b0, dest};
    forw   = dest_x >= c_id ? dest_x - c_id : dest_x + c_n - c_id;
    backw  = c_id >= dest_x ? c_id - dest_x : c_id + c_n - dest_x;
    tie    = 1'b0;
    if (dest_x >= c_n) route = 2'b11;
    else if (dest_x == c_id) route = 2'b10;
    else if (mode_i == 2'b01) route = 2'b01;
    else if (mode_i == 2'b10) route = 2'b00;
    else if (forw == backw) begin
      tie   = 1'b1;
      route = tog_q ? 2'b00 : 2'b01;
    end
    else route = forw < backw ? 2'b01 : 2'b00;
  end
  assign in_rdy_o     = count_q != 2'd2;
  assign out_val_o    = count_q != 2'd0;
  assign enq          = in_val_i & in_rdy_o;
  assign deq          = out_val_o & out_rdy_i;
  assign count_d      = count_q + {1'b0, enq} - {1'b0, deq};
  assign tog_d        = tog_q ^ (enq & tie);
  assign out_msg_o    = msg_q[head_q];
  assign out_route_o  = route_q[head_q];
  assign out_domain_o = dom_q[head_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      tog_q      <= 1'b0;
      msg_q[0]   <= '0;
      msg_q[1]   <= '0;
      route_q[0] <= '0;
      route_q[1] <= '0;
      dom_q[0]   <= 1'b0;
      dom_q[1]   <= 1'b0;
    end else begin
      if (enq) begin
        msg_q[tail_q]   <= in_msg_i;
        route_q[tail_q] <= route;
        dom_q[tail_q]   <= in_domain_i;
        tail_q          <= ~tail_q;
      end
      if (deq) head_q <= ~head_q;
      count_q <= count_d;
      tog_q   <= tog_d;
    end
  end
`ifdef PLAB4_NET_ROUTE_STATS_EN
  logic [15:0] stat_prev_q, stat_next_q, stat_term_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_prev_q <= '0;
      stat_next_q <= '0;
      stat_term_q <= '0;
    end else if (deq) begin
      if (out_route_o == 2'b00 && stat_prev_q != 16'hFFFF) stat_prev_q <= stat_prev_q + 16'd1;
      if (out_route_o == 2'b01 && stat_next_q != 16'hFFFF) stat_next_q <= stat_next_q + 16'd1;
      if (out_route_o == 2'b10 && stat_term_q != 16'hFFFF) stat_term_q <= stat_term_q + 16'd1;
    end
  end
  assign stat_prev_o = stat_prev_q;
  assign stat_next_o = stat_next_q;
  assign stat_term_o = stat_term_q;
`endif
endmodule

// File: tb/tb_plab4_net_route_compute_unit.sv
// tb_plab4_net_route_compute_unit: directed bench driving an N=8/id=2 and an N=6/id=0 instance from one input stream
module tb_plab4_net_route_compute_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        dom = 1'b0, in_val = 1'b0, out_rdy = 1'b1;
  logic [31:0] msg = '0;
  logic        rdy8, val8, dom8, rdy6, val6, dom6;
  logic [31:0] msg8, msg6;
  logic [1:0]  rt8, rt6;
`ifdef PLAB4_NET_ROUTE_STATS_EN
  logic [15:0] sp8, sn8, st8, sp6, sn6, st6;
`endif
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  plab4_net_route_compute_unit #(.p_router_id(2), .p_num_routers(8)) u8 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_domain_i(dom), .in_msg_i(msg),
    .in_val_i(in_val), .in_rdy_o(rdy8), .out_msg_o(msg8), .out_route_o(rt8),
    .out_domain_o(dom8), .out_val_o(val8), .out_rdy_i(out_rdy)
`ifdef PLAB4_NET_ROUTE_STATS_EN
    , .stat_prev_o(sp8), .stat_next_o(sn8), .stat_term_o(st8)
`endif
  );
  plab4_net_route_compute_unit #(.p_router_id(0), .p_num_routers(6)) u6 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .in_domain_i(dom), .in_msg_i(msg),
    .in_val_i(in_val), .in_rdy_o(rdy6), .out_msg_o(msg6), .out_route_o(rt6),
    .out_domain_o(dom6), .out_val_o(val6), .out_rdy_i(out_rdy)
`ifdef PLAB4_NET_ROUTE_STATS_EN
    , .stat_prev_o(sp6), .stat_next_o(sn6), .stat_term_o(st6)
`endif
  );
  function automatic logic [31:0] mk(input logic [2:0] d);
    return {5'b0, d, 16'hBEEF, 5'b0, d};
  endfunction
  task automatic send(input logic [2:0] d, input logic [1:0] m, input logic dm);
    @(negedge clk);
    in_val = 1'b1;
    msg    = mk(d);
    mode   = m;
    dom    = dm;
    @(negedge clk);
    in_val = 1'b0;
  endtask
  task automatic test_reset;
    #12;
    vec++;
    if (val8 !== 1'b0 || msg8 !== 32'h0 || rt8 !== 2'b00 || dom8 !== 1'b0) begin
      err++;
      $display("FAIL reset_outputs val=%b msg=%h route=%b dom=%b expected all zero", val8, msg8, rt8, dom8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++;
    if (rdy8 !== 1'b1 || rdy6 !== 1'b1 || val6 !== 1'b0) begin
      err++;
      $display("FAIL reset_release rdy8=%b rdy6=%b val6=%b expected 1 1 0", rdy8, rdy6, val6);
    end
  endtask
  task automatic test_greedy;
    logic [2:0] ds [3] = '{3'd2, 3'd5, 3'd7};
    logic [1:0] rs [3] = '{2'b10, 2'b01, 2'b00};
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ds[i], 2'b00, i[0]);
      vec++;
      if (val8 !== 1'b1 || rt8 !== rs[i] || msg8 !== mk(ds[i]) || dom8 !== i[0]) begin
        err++;
        $display("FAIL greedy[%0d] val=%b route=%b msg=%h dom=%b expected 1 %b %h %b",
                 i, val8, rt8, msg8, dom8, rs[i], mk(ds[i]), i[0]);
      end
    end
    @(negedge clk);
    vec++;
    if (val8 !== 1'b0) begin
      err++;
      $display("FAIL greedy_drain val=%b expected 0", val8);
    end
  endtask
  task automatic test_tie;
    logic [1:0] ms [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] rs [5] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 5; i++) begin
      send(3'd6, ms[i], 1'b0);
      vec++;
      if (val8 !== 1'b1 || rt8 !== rs[i]) begin
        err++;
        $display("FAIL tie[%0d] val=%b route=%b expected 1 %b", i, val8, rt8, rs[i]);
      end
    end
  endtask
  task automatic test_n6;
    logic [2:0] ds [4] = '{3'd6, 3'd5, 3'd3, 3'd7};
    logic [1:0] rs [4] = '{2'b11, 2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      send(ds[i], 2'b00, 1'b1);
      vec++;
      if (val6 !== 1'b1 || rt6 !== rs[i] || msg6 !== mk(ds[i])) begin
        err++;
        $display("FAIL n6[%0d] val=%b route=%b msg=%h expected 1 %b %h", i, val6, rt6, msg6, rs[i], mk(ds[i]));
      end
    end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    out_rdy = 1'b0;
    in_val  = 1'b1;
    msg     = mk(3'd5);
    dom     = 1'b1;
    mode    = 2'b00;
    #1;
    vec++;
    if (val8 !== 1'b0) begin
      err++;
      $display("FAIL bp_no_comb_path val=%b expected 0", val8);
    end
    @(negedge clk);
    vec++;
    if (rdy8 !== 1'b1 || val8 !== 1'b1 || msg8 !== mk(3'd5)) begin
      err++;
      $display("FAIL bp_first rdy=%b val=%b msg=%h expected 1 1 %h", rdy8, val8, msg8, mk(3'd5));
    end
    msg = mk(3'd7);
    dom = 1'b0;
    @(negedge clk);
    msg = mk(3'd2);
    dom = 1'b1;
    @(negedge clk);
    vec++;
    if (rdy8 !== 1'b0 || val8 !== 1'b1 || msg8 !== mk(3'd5) || rt8 !== 2'b01 || dom8 !== 1'b1) begin
      err++;
      $display("FAIL bp_stall rdy=%b val=%b msg=%h route=%b dom=%b expected 0 1 %h 01 1",
               rdy8, val8, msg8, rt8, dom8, mk(3'd5));
    end
    out_rdy = 1'b1;
    @(negedge clk);
    vec++;
    if (rdy8 !== 1'b1 || msg8 !== mk(3'd7) || rt8 !== 2'b00 || dom8 !== 1'b0) begin
      err++;
      $display("FAIL bp_second rdy=%b msg=%h route=%b dom=%b expected 1 %h 00 0", rdy8, msg8, rt8, dom8, mk(3'd7));
    end
    @(negedge clk);
    in_val = 1'b0;
    vec++;
    if (val8 !== 1'b1 || msg8 !== mk(3'd2) || rt8 !== 2'b10 || dom8 !== 1'b1) begin
      err++;
      $display("FAIL bp_third val=%b msg=%h route=%b dom=%b expected 1 %h 10 1", val8, msg8, rt8, dom8, mk(3'd2));
    end
    @(negedge clk);
    vec++;
    if (val8 !== 1'b0) begin
      err++;
      $display("FAIL bp_drain val=%b expected 0", val8);
    end
  endtask
  task automatic test_async_reset;
    @(negedge clk);
    out_rdy = 1'b0;
    in_val  = 1'b1;
    msg     = mk(3'd5);
    @(negedge clk);
    msg = mk(3'd7);
    @(negedge clk);
    in_val = 1'b0;
    vec++;
    if (val8 !== 1'b1 || rdy8 !== 1'b0) begin
      err++;
      $display("FAIL areset_full val=%b rdy=%b expected 1 0", val8, rdy8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (val8 !== 1'b0 || rdy8 !== 1'b1 || msg8 !== 32'h0 || rt8 !== 2'b00 || val6 !== 1'b0) begin
      err++;
      $display("FAIL areset_clear val=%b rdy=%b msg=%h route=%b val6=%b expected 0 1 0 00 0",
               val8, rdy8, msg8, rt8, val6);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    send(3'd6, 2'b00, 1'b0);
    vec++;
    if (val8 !== 1'b1 || rt8 !== 2'b01) begin
      err++;
      $display("FAIL areset_tie val=%b route=%b expected 1 01", val8, rt8);
    end
    send(3'd5, 2'b00, 1'b1);
    vec++;
    if (rt8 !== 2'b01 || dom8 !== 1'b1 || msg8 !== mk(3'd5)) begin
      err++;
      $display("FAIL areset_next route=%b dom=%b msg=%h expected 01 1 %h", rt8, dom8, msg8, mk(3'd5));
    end
    @(negedge clk);
  endtask
`ifdef PLAB4_NET_ROUTE_STATS_EN
  task automatic test_stats;
    logic [2:0] ds [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd6};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) send(ds[i], 2'b00, 1'b0);
    @(negedge clk);
    vec++;
    if (st6 !== 16'd3 || sn6 !== 16'd2 || sp6 !== 16'd0) begin
      err++;
      $display("FAIL stats_count term=%0d next=%0d prev=%0d expected 3 2 0", st6, sn6, sp6);
    end
    force u6.stat_next_q = 16'hFFFF;
    @(negedge clk);
    release u6.stat_next_q;
    send(3'd1, 2'b00, 1'b0);
    @(negedge clk);
    vec++;
    if (sn6 !== 16'hFFFF) begin
      err++;
      $display("FAIL stats_saturate next=%h expected ffff", sn6);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_greedy();
    test_tie();
    test_n6();
    test_back_to_back();
    test_async_reset();
`ifdef PLAB4_NET_ROUTE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
